// File: rtl/carry_chk_pkg.sv
// Shared FSM state type, counter constants and majority helper for the carry-chain checker.
// Definitions only: no latency, no backpressure.
package carry_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int               CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_SAT = 16'hFFFF;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/carry_chk_sat_cnt.sv
// 16-bit saturating event counter; increments one cycle after inc_i, holds at CNT_SAT.
// No backpressure: every inc_i below saturation is counted.
module carry_chk_sat_cnt
  import carry_chk_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != CNT_SAT)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/carry_chain_checker.sv
// Bit-serial ripple-carry checker: done_o WIDTH+1 cycles after accept, one sample per WIDTH+2 cycles.
// rdy_o only in IDLE, vld_i ignored otherwise; CARRY_CHAIN_CHECKER_STICKY_EN adds sticky_err_o.
module carry_chain_checker
  import carry_chk_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vld_i,
  output logic                     rdy_o,
  input  logic [WIDTH-1:0]         a_i,
  input  logic [WIDTH-1:0]         b_i,
  input  logic                     c0_i,
  input  logic [WIDTH-1:0]         c_i,
  output logic                     done_o,
  output logic                     err_o,
  output logic [$clog2(WIDTH)-1:0] err_bit_o,
  output logic [CNT_W-1:0]         pass_cnt_o,
  output logic [CNT_W-1:0]         fail_cnt_o
`ifdef CARRY_CHAIN_CHECKER_STICKY_EN
  ,
  output logic                     sticky_err_o
`endif
);

  localparam int IW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic             carry_q, carry_d;
  logic [IW-1:0]    bit_q, bit_d;
  logic             err_seen_q, err_seen_d;
  logic [IW-1:0]    err_idx_q, err_idx_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [IW-1:0]    err_bit_q, err_bit_d;
  logic             ref_bit, mismatch;
  logic             pass_inc, fail_inc;

  // Reference carry for the bit currently under test.
  assign ref_bit  = maj(a_q[bit_q], b_q[bit_q], carry_q);
  assign mismatch = ref_bit ^ c_q[bit_q];

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    carry_d    = carry_q;
    bit_d      = bit_q;
    err_seen_d = err_seen_q;
    err_idx_d  = err_idx_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_bit_d  = err_bit_q;
    case (state_q)
      ST_IDLE: begin
        if (vld_i) begin
          a_d        = a_i;
          b_d        = b_i;
          c_d        = c_i;
          carry_d    = c0_i;
          bit_d      = '0;
          err_seen_d = 1'b0;
          err_idx_d  = '0;
          state_d    = ST_CHECK;
        end
      end
      ST_CHECK: begin
        carry_d = ref_bit;
        // Only the first mismatch of a sample records its index.
        if (mismatch && !err_seen_q) begin
          err_seen_d = 1'b1;
          err_idx_d  = bit_q;
        end
        if (bit_q == IW'(WIDTH - 1)) begin
          bit_d   = '0;
          state_d = ST_DONE;
        end else begin
          bit_d = bit_q + IW'(1);
        end
      end
      ST_DONE: begin
        done_d    = 1'b1;
        err_d     = err_seen_q;
        err_bit_d = err_seen_q ? err_idx_q : '0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef CARRY_CHAIN_CHECKER_STICKY_EN
  logic sticky_q, sticky_d;
  assign sticky_d     = sticky_q | ((state_q == ST_DONE) && err_seen_q);
  assign sticky_err_o = sticky_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      carry_q    <= 1'b0;
      bit_q      <= '0;
      err_seen_q <= 1'b0;
      err_idx_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_bit_q  <= '0;
`ifdef CARRY_CHAIN_CHECKER_STICKY_EN
      sticky_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      carry_q    <= carry_d;
      bit_q      <= bit_d;
      err_seen_q <= err_seen_d;
      err_idx_q  <= err_idx_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_bit_q  <= err_bit_d;
`ifdef CARRY_CHAIN_CHECKER_STICKY_EN
      sticky_q   <= sticky_d;
`endif
    end
  end

  assign pass_inc = (state_q == ST_DONE) && !err_seen_q;
  assign fail_inc = (state_q == ST_DONE) &&  err_seen_q;

  carry_chk_sat_cnt u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (pass_inc),
    .cnt_o (pass_cnt_o)
  );

  carry_chk_sat_cnt u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (fail_inc),
    .cnt_o (fail_cnt_o)
  );

  assign rdy_o     = (state_q == ST_IDLE);
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign err_bit_o = err_bit_q;

endmodule

// File: tb/tb_carry_chain_checker.sv
// Scoreboard bench for carry_chain_checker (WIDTH=8): expected results are queued at
// acceptance and compared at each done_o pulse.
`timescale 1ns/1ps
module tb_carry_chain_checker;
  import carry_chk_pkg::*;

  localparam int W  = 8;
  localparam int IW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vld_i = 1'b0;
  logic          c0_i = 1'b0;
  logic [W-1:0]  a_i = '0, b_i = '0, c_i = '0;
  logic          rdy_o, done_o, err_o;
  logic [IW-1:0] err_bit_o;
  logic [15:0]   pass_cnt_o, fail_cnt_o;

  always #5 clk = ~clk;

  carry_chain_checker #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vld_i      (vld_i),
    .rdy_o      (rdy_o),
    .a_i        (a_i),
    .b_i        (b_i),
    .c0_i       (c0_i),
    .c_i        (c_i),
    .done_o     (done_o),
    .err_o      (err_o),
    .err_bit_o  (err_bit_o),
    .pass_cnt_o (pass_cnt_o),
    .fail_cnt_o (fail_cnt_o)
  );

  typedef struct {
    logic          err;
    logic [IW-1:0] idx;
    logic          carry;
    int            nmis;
    int            acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0, cyc = 0, mis_seen = 0;
  int   exp_pass = 0, exp_fail = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Carry out of bit k taken from an arithmetic sum of the low k+1 bits.
  function automatic logic [W-1:0] ref_carries(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic c0);
    logic [W-1:0] r;
    logic [W:0]   s, m;
    r = '0;
    for (int k = 0; k < W; k++) begin
      m    = (W+1)'((1 << (k + 1)) - 1);
      s    = ({1'b0, a} & m) + ({1'b0, b} & m) + (W+1)'(c0);
      r[k] = s[k+1];
    end
    return r;
  endfunction

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] c, input logic c0);
    exp_t         e;
    logic [W-1:0] r, d;
    r       = ref_carries(a, b, c0);
    d       = r ^ c;
    e.err   = |d;
    e.idx   = '0;
    e.nmis  = $countones(d);
    e.carry = r[W-1];
    e.acc   = 0;
    for (int k = W - 1; k >= 0; k--) if (d[k]) e.idx = IW'(k);
    return e;
  endfunction

  // Output monitor: pops the scoreboard on every done_o.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      mis_seen  = 0;
      exp_pass  = 0;
      exp_fail  = 0;
      prev_done = 1'b0;
    end else begin
      if (dut.state_q == ST_CHECK && dut.mismatch) mis_seen++;
      if (done_o) begin
        check_eq("done_pulse_width", prev_done, 1'b0);
        if (sb.size() == 0) begin
          check_eq("spurious_done", done_o, 1'b0);
        end else begin
          e = sb.pop_front();
          if (e.err) exp_fail = (exp_fail == 16'hFFFF) ? exp_fail : exp_fail + 1;
          else       exp_pass = (exp_pass == 16'hFFFF) ? exp_pass : exp_pass + 1;
          check_eq("latency", cyc - e.acc, W + 1);
          check_eq("err_o", err_o, e.err);
          check_eq("err_bit_o", err_bit_o, e.idx);
          check_eq("bits_mismatched", mis_seen, e.nmis);
          check_eq("final_carry", dut.carry_q, e.carry);
          check_eq("pass_cnt_o", pass_cnt_o, exp_pass);
          check_eq("fail_cnt_o", fail_cnt_o, exp_fail);
        end
        mis_seen = 0;
      end
      prev_done = done_o;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                      input logic c0, input bit hold, output int acc);
    int   guard;
    exp_t e;
    @(negedge clk);
    a_i = a; b_i = b; c_i = c; c0_i = c0; vld_i = 1'b1;
    guard = 0;
    while (!rdy_o && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_eq("accept_timeout", guard >= 100, 1'b0);
    e     = model(a, b, c, c0);
    e.acc = cyc + 1;
    acc   = e.acc;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (!hold) vld_i = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((sb.size() != 0 || !rdy_o) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_eq("drain_timeout", guard >= 200, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int           acc1, acc2, ndone;
    logic [W-1:0] ra, rb, rc;
    logic         rc0;

    repeat (3) @(negedge clk);
    check_eq("rst_rdy_o", rdy_o, 1'b1);
    check_eq("rst_done_o", done_o, 1'b0);
    check_eq("rst_err_o", err_o, 1'b0);
    check_eq("rst_err_bit_o", err_bit_o, '0);
    check_eq("rst_pass_cnt", pass_cnt_o, 16'h0);
    check_eq("rst_fail_cnt", fail_cnt_o, 16'h0);
    rst_n = 1'b1;
    @(negedge clk);

    send(8'hFF, 8'h00, 8'hFF, 1'b1, 1'b0, acc1);
    wait_drain();
    check_eq("all_ones_pass_cnt", pass_cnt_o, 16'd1);

    send(8'h01, 8'h03, 8'h03, 1'b1, 1'b0, acc1);
    send(8'h01, 8'h03, 8'h07, 1'b1, 1'b0, acc1);
    wait_drain();
    check_eq("bit2_err_o", err_o, 1'b1);
    check_eq("bit2_err_bit_o", err_bit_o, 3'd2);
    check_eq("bit2_fail_cnt", fail_cnt_o, 16'd1);

    send(8'h55, 8'hAA, 8'hFE, 1'b1, 1'b0, acc1);
    wait_drain();
    check_eq("bit0_err_bit_o", err_bit_o, 3'd0);

    // Second sample is presented immediately with vld_i held; the first check must be unaffected.
    send(8'h20, 8'h20, 8'h20, 1'b0, 1'b1, acc1);
    send(8'h01, 8'h01, 8'h01, 1'b0, 1'b0, acc2);
    check_eq("b2b_accept_spacing", acc2 - acc1, W + 2);
    wait_drain();

    for (int i = 0; i < 16; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rc0 = 1'($urandom_range(0, 1));
      rc  = ref_carries(ra, rb, rc0);
      if (i % 3 == 0) rc = rc ^ W'($urandom_range(1, (1 << W) - 1));
      send(ra, rb, rc, rc0, (i % 4 == 1), acc1);
    end
    vld_i = 1'b0;
    wait_drain();

    send(8'h0F, 8'h01, 8'h0F, 1'b0, 1'b0, acc1);
    repeat (4) @(negedge clk);
    check_eq("abort_at_bit4", dut.bit_q, 3'd4);
    rst_n = 1'b0;
    #1;
    check_eq("abort_rdy_in_rst", rdy_o, 1'b1);
    check_eq("abort_done_in_rst", done_o, 1'b0);
    check_eq("abort_err_in_rst", err_o, 1'b0);
    check_eq("abort_err_bit_in_rst", err_bit_o, '0);
    check_eq("abort_pass_in_rst", pass_cnt_o, 16'h0);
    check_eq("abort_fail_in_rst", fail_cnt_o, 16'h0);
    check_eq("abort_carry_in_rst", dut.carry_q, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done_o) ndone++;
    end
    check_eq("abort_no_done", ndone, 0);
    check_eq("abort_rdy_after", rdy_o, 1'b1);
    check_eq("abort_pass_after", pass_cnt_o, 16'h0);
    check_eq("abort_fail_after", fail_cnt_o, 16'h0);

    send(8'h01, 8'h03, 8'h07, 1'b1, 1'b0, acc1);
    wait_drain();
    force dut.u_pass_cnt.cnt_d = 16'hFFFE;
    @(negedge clk);
    release dut.u_pass_cnt.cnt_d;
    exp_pass = 16'hFFFE;
    @(negedge clk);
    check_eq("preload_pass_cnt", pass_cnt_o, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      send(8'hFF, 8'h00, 8'hFF, 1'b1, 1'b0, acc1);
      wait_drain();
      check_eq("sat_pass_cnt", pass_cnt_o, 16'hFFFF);
    end
    check_eq("sat_fail_cnt", fail_cnt_o, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
